// File: rtl/frame_scheduler_if.sv
// Control bundle between the frame scheduler and the game update units.
// The slave side is the scheduler; the master side drives triggers and step completions.
interface frame_scheduler_if;
    logic       frame_start;
    logic       pause;
    logic [3:0] step_en;
    logic [3:0] step_done;
    logic [3:0] step_req;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       timeout_err;
    logic [7:0] overrun_cnt;

    modport master (
        output frame_start,
        output pause,
        output step_en,
        output step_done,
        input  step_req,
        input  busy,
        input  frame_done,
        input  frame_cnt,
        input  timeout_err,
        input  overrun_cnt
    );

    modport slave (
        input  frame_start,
        input  pause,
        input  step_en,
        input  step_done,
        output step_req,
        output busy,
        output frame_done,
        output frame_cnt,
        output timeout_err,
        output overrun_cnt
    );
endinterface

// File: rtl/frame_scheduler.sv
// Sequences the per-frame update steps (player, bullets, invaders, collision)
// once per vertical blank, with a per-step watchdog and frame/overrun counters.
module frame_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] wait_q, wait_d;
    logic [3:0]  en_q, en_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  overrun_cnt_q, overrun_cnt_d;

    logic        first_vld;
    logic [1:0]  first_idx;
    logic        next_vld;
    logic [1:0]  next_idx;
    logic        cur_done;
    logic        cur_tmo;
    logic [3:0]  step_req;
    logic        timeout_err;

    // Lowest enabled step overall, and lowest latched step above the current one.
    always_comb begin
        first_vld = 1'b0;
        first_idx = 2'd0;
        next_vld  = 1'b0;
        next_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.step_en[i]) begin
                first_vld = 1'b1;
                first_idx = 2'(i);
            end
            if (en_q[i] && (i > int'(idx_q))) begin
                next_vld = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        en_d          = en_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        step_req      = 4'd0;
        timeout_err   = 1'b0;
        cur_done      = 1'b0;
        cur_tmo       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.frame_start && !bus.pause) begin
                    en_d   = bus.step_en;
                    idx_d  = first_idx;
                    wait_d = 16'd0;
                    if (first_vld) begin
                        state_d = RUN;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RUN: begin
                step_req = 4'b0001 << idx_q;
                cur_done = bus.step_done[idx_q];
                cur_tmo  = !cur_done && (wait_q == WAIT_MAX);
                // Completion and watchdog abort advance the sequence identically.
                if (cur_done || cur_tmo) begin
                    timeout_err = cur_tmo;
                    wait_d      = 16'd0;
                    if (next_vld) begin
                        idx_d = next_idx;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            FINISH: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.frame_start && (state_q != IDLE) && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            wait_q        <= 16'd0;
            en_q          <= 4'd0;
            frame_cnt_q   <= 8'd0;
            overrun_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            en_q          <= en_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign bus.step_req    = step_req;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = (state_q == FINISH);
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.timeout_err = timeout_err;
    assign bus.overrun_cnt = overrun_cnt_q;

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum cycles a step may hold its request before abort (range 2..65535).
REQ-002 clk  input  1  system clock, the same clock that drives the chipinvaders game logic.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 frame_start  input  1  single-cycle pulse at start of vertical blanking.
REQ-005 pause  input  1  level; when high, new frames are not sequenced.
REQ-006 step_en  input  4  per-step enable; bit0 player, bit1 bullets, bit2 invaders, bit3 collision.
REQ-007 step_done  input  4  per-step completion, sampled only on the currently requested bit.
REQ-008 step_req  output  4  one-hot-or-zero request to the update units.
REQ-009 busy  output  1  high while a frame is being sequenced.
REQ-010 frame_done  output  1  single-cycle pulse when a frame sequence completes.
REQ-011 frame_cnt  output  8  count of completed frames.
REQ-012 timeout_err  output  1  single-cycle pulse when a step is aborted.
REQ-013 overrun_cnt  output  8  count of dropped frame_start pulses.

Function
REQ-014 States: IDLE, RUN, FINISH; RUN carries a 2-bit step index and a 16-bit wait counter.
REQ-015 IDLE: frame_start=1 and pause=0 -> RUN at the first enabled step (lowest set step_en bit, sampled at the frame_start cycle and latched for the whole frame); step_req of that step is high at frame_start cycle +1.
REQ-016 IDLE: frame_start=1 with pause=1 -> ignored; no request, no counter change.
REQ-017 Latched enable mask all zero -> go directly to FINISH; no step_req asserted.
REQ-018 RUN: step_req[idx] is held high, and all other step_req bits are held low, until step_done[idx] is sampled high.
REQ-019 On step_done[idx]=1: the next cycle raises step_req of the next higher enabled step, or enters FINISH with step_req=0 when no higher step is enabled; no idle cycle between steps.
REQ-020 step_done bits other than step_done[idx], and any step_done while in IDLE or FINISH, are ignored.
REQ-021 Wait counter clears on entry to each step and increments each cycle step_done[idx]=0.
REQ-022 When the wait counter reaches TIMEOUT_CYCLES-1 with step_done[idx]=0, the step is aborted:
  - timeout_err pulses for that cycle;
  - the following cycle proceeds exactly as in REQ-019.
REQ-023 If step_done[idx]=1 in the same cycle the counter reaches TIMEOUT_CYCLES-1, done wins; no timeout_err.
REQ-024 FINISH lasts exactly one cycle:
  - frame_done=1;
  - frame_cnt increments, wrapping 255->0;
  - next state is IDLE.
REQ-025 busy=1 in RUN and FINISH, 0 in IDLE.
REQ-026 frame_start while busy=1 is dropped, never queued; overrun_cnt increments, saturating at 255.
REQ-027 frame_start in the FINISH cycle counts as an overrun per REQ-026.
REQ-028 pause rising during RUN does not interrupt; the current frame completes normally.
REQ-029 step_en changes during RUN have no effect until the next frame.

Reset
REQ-030 rst_n=0 asynchronously forces:
  - state IDLE;
  - step_req=0, busy=0, frame_done=0, timeout_err=0;
  - frame_cnt=0, overrun_cnt=0;
  - step index and wait counter cleared.
REQ-031 Reset mid-RUN drops the active request immediately without completing the frame.
REQ-032 After rst_n rises, the first frame_start at least one cycle later is accepted.

Verification
REQ-033 step_en=4'b1111, frame_start pulse, each step_done returned 3 cycles after its req -> step_req sequence 0001,0010,0100,1000; frame_done pulse; frame_cnt=1.
REQ-034 step_en=4'b0101 -> only bits 0 and 2 requested; step_en=4'b0000 -> frame_done at frame_start+1, frame_cnt incremented, step_req stays 0.
REQ-035 TIMEOUT_CYCLES=8, step_done never returned for step 0 -> timeout_err after 8 request cycles; step 1 requested next cycle; frame completes.
REQ-036 frame_start pulses 3 times while busy -> overrun_cnt=3; 300 overruns -> overrun_cnt=255.
REQ-037 pause=1 with frame_start -> no request and frame_cnt unchanged; 256 completed frames -> frame_cnt wraps to 0.
REQ-038 rst_n asserted while step_req=0100 -> all outputs zero in the same cycle; next frame_start starts at step 0.
